mem_access_unit: RTL and testbench
==================================

# mem_access_unit

- Sits in the MEM stage directly upstream of `dataMemory`; converts EX/MEM load/store requests into word-only memory accesses.
- Handles byte/halfword loads with sign/zero extension and word/halfword/byte stores.
- Sub-word stores use a two-cycle read-modify-write, stalling the pipeline for one cycle; word accesses complete in one cycle.
- Detects misaligned accesses, suppresses them, and records the first one in a sticky fault register.

## Interface
- `bits`, default 32: data/address width; lane logic is defined for 32 only.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_op`  in  4  operation: 0 NONE, 1 LW, 2 LH, 3 LHU, 4 LB, 5 LBU, 8 SW, 9 SH, 10 SB; any other code is NONE.
- `req_address`  in  32  byte address from EX/MEM.
- `req_store_data`  in  32  store source; SH uses [15:0], SB uses [7:0].
- `load_data`  out  32  extended load result to MEM/WB.
- `stall`  out  1  pipeline must hold EX/MEM and upstream stages this cycle.
- `misaligned`  out  1  current request is misaligned (combinational).
- `fault_valid`  out  1  sticky: a misaligned access has occurred.
- `fault_address`  out  32  address of the first misaligned access.
- `mem_address`  out  32  to `dataMemory` address; word-aligned, so [1:0] = 0.
- `mem_write_data`  out  32  to `dataMemory` write data.
- `mem_read_data`  in  32  from `dataMemory`; combinational read.
- `mem_write`  out  1  to `dataMemory` write enable.
- `mem_read`  out  1  to `dataMemory` read enable.

## Operation

**Byte order**
- Big-endian. Byte offset 0 maps to [31:24], offset 3 to [7:0].
- Halfword offset 0 maps to [31:16], offset 2 to [15:0].

**Alignment**
- LW/SW: misaligned if address[1:0] ≠ 0.
- LH/LHU/SH: misaligned if address[0] ≠ 0.
- Byte operations are never misaligned.
- A misaligned request drives `mem_read` = `mem_write` = 0, `load_data` = 0, and `stall` = 0.

**Loads** (state IDLE only)
- `mem_read` = 1 and `mem_address` = {address[31:2], 2'b00}.
- `load_data` is the selected lane of `mem_read_data`.
- LH/LB sign-extend the lane; LHU/LBU zero-extend it.

**SW**
- Completes in IDLE with `mem_write` = 1 and `mem_write_data` = `req_store_data`.

**SH/SB** (FSM states IDLE, RMW_WRITE)
- In IDLE with an aligned SH/SB:
  - drive `mem_read` = 1 and `stall` = 1;
  - on the clock edge, latch the merge word (`mem_read_data` with the target lane replaced) and the word address;
  - go to RMW_WRITE.
- In RMW_WRITE:
  - drive `mem_write` = 1, `mem_write_data` = merge word, `mem_address` = latched address, `stall` = 0;
  - `req_*` inputs are ignored;
  - unconditionally return to IDLE.

**NONE**
- All memory enables are 0, `load_data` = 0, `stall` = 0.

**Fault register**
- On the first clock edge where `misaligned` = 1 and `fault_valid` = 0: set `fault_valid` and capture `req_address`.
- Later faults do not overwrite the captured address.
- Cleared only by reset.

## Timing
- Loads, SW, and misaligned requests: 0 cycles of stall.
- SH/SB: exactly 1 stall cycle; the memory write happens at the end of the second cycle.
- The pipeline holds `req_*` stable while `stall` = 1.
- Reset values: state IDLE, merge word 0, latched address 0, `fault_valid` 0, `fault_address` 0.
- Outputs while `reset_n` = 0: `stall` 0, `mem_write` 0, `mem_read` 0, `load_data` 0.
- Reset asserted in RMW_WRITE aborts the operation: no write occurs and state returns to IDLE immediately.
- `misaligned` depends only on `req_op` and `req_address`, including in RMW_WRITE. Because inputs are ignored in RMW_WRITE, a fault can only be captured in IDLE.
- Back-to-back SB then SB: the second request is sampled in IDLE on the cycle after RMW_WRITE. There is no overlap and no merge forwarding needed, because the first write has landed by then.

## Structure
- Package `mem_access_pkg` holds:
  - the `req_op` code constants;
  - FSM state encoding (IDLE = 0, RMW_WRITE = 1);
  - lane-select helper constants.
- Sub-module `load_aligner`: combinational lane select plus sign/zero extension. It takes `req_op`, address[1:0] and `mem_read_data`, and outputs `load_data`.
- The FSM, merge register and fault register live in `mem_access_unit`, which instantiates `load_aligner`.

## Test plan
All scenarios assume memory is zero-initialised.
1. SW 0x8899AABB to 0x10, then LW 0x10, LB 0x11, LBU 0x11:
   - `load_data` = 0x8899AABB, then 0xFFFFFF99, then 0x00000099;
   - no stall.
2. After scenario 1, SB 0x55 to 0x12:
   - `stall` = 1 for one cycle;
   - `mem_write` pulses in the second cycle with 0x8899 55BB (word 0x889955BB);
   - a following LW 0x10 returns 0x889955BB.
3. SH 0x1234 to 0x16, then LH 0x16 and LHU 0x14:
   - word 0x14 reads 0x00001234;
   - `load_data` = 0x00001234, then 0x00000000.
4. LW 0x21, then SH 0x33:
   - `misaligned` = 1 on both and no `mem_write`;
   - `fault_valid` = 1 and `fault_address` = 0x21, still 0x21 after the second fault.
5. Reset asserted during RMW_WRITE of SB 0xFF to 0x40:
   - word 0x40 remains 0;
   - FSM in IDLE, `fault_valid` = 0.
6. SB 0x01 to 0x50 back-to-back with SB 0x02 to 0x51:
   - two separate stall cycles;
   - final word 0x50 = 0x01020000.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM-stage access unit: request opcodes, RMW FSM
// states and big-endian lane-position helpers.
package mem_access_pkg;

   localparam logic [3:0] OP_NONE = 4'd0;
   localparam logic [3:0] OP_LW   = 4'd1;
   localparam logic [3:0] OP_LH   = 4'd2;
   localparam logic [3:0] OP_LHU  = 4'd3;
   localparam logic [3:0] OP_LB   = 4'd4;
   localparam logic [3:0] OP_LBU  = 4'd5;
   localparam logic [3:0] OP_SW   = 4'd8;
   localparam logic [3:0] OP_SH   = 4'd9;
   localparam logic [3:0] OP_SB   = 4'd10;

   typedef enum logic {
      IDLE      = 1'b0,
      RMW_WRITE = 1'b1
   } stateT;

   localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;
   localparam logic [31:0] HALF_MASK = 32'h0000_FFFF;

   // Big-endian: byte offset 0 lives in [31:24], so its lane sits 24 bits up.
   function automatic logic [4:0] byteShift(input logic [1:0] offset);
      return 5'd24 - {offset, 3'b000};
   endfunction

   function automatic logic [4:0] halfShift(input logic [1:0] offset);
      return offset[1] ? 5'd0 : 5'd16;
   endfunction

endpackage

// File: rtl/load_aligner.sv
// Picks the addressed byte/halfword lane out of a memory word and extends it
// to full width for the write-back stage.
module load_aligner
   import mem_access_pkg::*;
#(
   parameter int bits = 32
) (
   input  logic [3:0]      req_op,
   input  logic [1:0]      byteOffset,
   input  logic [bits-1:0] mem_read_data,
   output logic [bits-1:0] load_data
);

   logic [bits-1:0] byteWord;
   logic [bits-1:0] halfWord;
   logic [7:0]      byteLane;
   logic [15:0]     halfLane;

   always_comb begin
      byteWord = mem_read_data >> byteShift(byteOffset);
      halfWord = mem_read_data >> halfShift(byteOffset);
      byteLane = byteWord[7:0];
      halfLane = halfWord[15:0];
   end

   always_comb begin
      load_data = '0;
      case (req_op)
         OP_LW:   load_data = mem_read_data;
         OP_LH:   load_data = {{(bits-16){halfLane[15]}}, halfLane};
         OP_LHU:  load_data = {{(bits-16){1'b0}}, halfLane};
         OP_LB:   load_data = {{(bits-8){byteLane[7]}}, byteLane};
         OP_LBU:  load_data = {{(bits-8){1'b0}}, byteLane};
         default: load_data = '0;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage front end for a word-only data memory: sub-word loads are lane
// selected, sub-word stores run a one-stall read-modify-write.
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int bits = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [3:0]      req_op,
   input  logic [bits-1:0] req_address,
   input  logic [bits-1:0] req_store_data,
   output logic [bits-1:0] load_data,
   output logic            stall,
   output logic            misaligned,
   output logic            fault_valid,
   output logic [bits-1:0] fault_address,
   output logic [bits-1:0] mem_address,
   output logic [bits-1:0] mem_write_data,
   input  logic [bits-1:0] mem_read_data,
   output logic            mem_write,
   output logic            mem_read
);

   stateT           stateReg, stateNext;
   logic [bits-1:0] mergeReg;
   logic [bits-1:0] addrReg;
   logic            faultValidReg;
   logic [bits-1:0] faultAddrReg;

   logic [bits-1:0] wordAddr;
   logic [bits-1:0] laneMask;
   logic [bits-1:0] laneData;
   logic [bits-1:0] mergeWord;
   logic [bits-1:0] alignedData;
   logic            loadEnable;

   assign wordAddr = {req_address[bits-1:2], 2'b00};

   always_comb begin
      misaligned = 1'b0;
      case (req_op)
         OP_LW, OP_SW:          misaligned = |req_address[1:0];
         OP_LH, OP_LHU, OP_SH:  misaligned = req_address[0];
         default:               misaligned = 1'b0;
      endcase
   end

   // Merge word: the fetched memory word with only the target lane replaced.
   always_comb begin
      if (req_op == OP_SH) begin
         laneMask = HALF_MASK << halfShift(req_address[1:0]);
         laneData = (req_store_data & HALF_MASK) << halfShift(req_address[1:0]);
      end else begin
         laneMask = BYTE_MASK << byteShift(req_address[1:0]);
         laneData = (req_store_data & BYTE_MASK) << byteShift(req_address[1:0]);
      end
      mergeWord = (mem_read_data & ~laneMask) | laneData;
   end

   load_aligner #(
      .bits(bits)
   ) uLoadAligner (
      .req_op       (req_op),
      .byteOffset   (req_address[1:0]),
      .mem_read_data(mem_read_data),
      .load_data    (alignedData)
   );

   always_comb begin
      stateNext      = stateReg;
      stall          = 1'b0;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      mem_address    = wordAddr;
      mem_write_data = req_store_data;
      loadEnable     = 1'b0;
      case (stateReg)
         IDLE: begin
            if (!misaligned) begin
               case (req_op)
                  OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: begin
                     mem_read   = 1'b1;
                     loadEnable = 1'b1;
                  end
                  OP_SW: mem_write = 1'b1;
                  OP_SH, OP_SB: begin
                     mem_read  = 1'b1;
                     stall     = 1'b1;
                     stateNext = RMW_WRITE;
                  end
                  default: ;
               endcase
            end
         end
         RMW_WRITE: begin
            mem_write      = 1'b1;
            mem_address    = addrReg;
            mem_write_data = mergeReg;
            stateNext      = IDLE;
         end
         default: stateNext = IDLE;
      endcase
      // Reset must also kill a write already in flight in RMW_WRITE.
      if (!reset_n) begin
         stall      = 1'b0;
         mem_read   = 1'b0;
         mem_write  = 1'b0;
         loadEnable = 1'b0;
      end
   end

   assign load_data = loadEnable ? alignedData : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stateReg      <= IDLE;
         mergeReg      <= '0;
         addrReg       <= '0;
         faultValidReg <= 1'b0;
         faultAddrReg  <= '0;
      end else begin
         stateReg <= stateNext;
         if (stateReg == IDLE && stall) begin
            mergeReg <= mergeWord;
            addrReg  <= wordAddr;
         end
         if (stateReg == IDLE && misaligned && !faultValidReg) begin
            faultValidReg <= 1'b1;
            faultAddrReg  <= req_address;
         end
      end
   end

   assign fault_valid   = faultValidReg;
   assign fault_address = faultAddrReg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a word memory stands in for dataMemory, and a
// per-cycle reference model plus directed literal checks judge the outputs.
module tb_mem_access_unit;
   import mem_access_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [3:0]  req_op = OP_NONE;
   logic [31:0] req_address = '0;
   logic [31:0] req_store_data = '0;
   logic [31:0] load_data;
   logic        stall;
   logic        misaligned;
   logic        fault_valid;
   logic [31:0] fault_address;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;
   logic        mem_write;
   logic        mem_read;

   int vectors = 0;
   int fails = 0;
   int stallCount = 0;

   logic [31:0] dutMem [0:63];
   logic [31:0] refMem [0:63];

   mem_access_unit #(.bits(32)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .req_op        (req_op),
      .req_address   (req_address),
      .req_store_data(req_store_data),
      .load_data     (load_data),
      .stall         (stall),
      .misaligned    (misaligned),
      .fault_valid   (fault_valid),
      .fault_address (fault_address),
      .mem_address   (mem_address),
      .mem_write_data(mem_write_data),
      .mem_read_data (mem_read_data),
      .mem_write     (mem_write),
      .mem_read      (mem_read)
   );

   always #5 clk = ~clk;

   assign mem_read_data = dutMem[mem_address[7:2]];
   always @(posedge clk) if (mem_write) dutMem[mem_address[7:2]] <= mem_write_data;
   always @(negedge clk) if (stall) stallCount++;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic isMis(input logic [3:0] op, input logic [31:0] a);
      if (op == OP_LW || op == OP_SW) return a[1:0] != 2'b00;
      if (op == OP_LH || op == OP_LHU || op == OP_SH) return a[0];
      return 1'b0;
   endfunction

   function automatic logic [31:0] refLoad(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] w);
      int bpos = 8 * (3 - int'(a[1:0]));
      int hpos = a[1] ? 0 : 16;
      logic [7:0]  b = w[bpos +: 8];
      logic [15:0] h = w[hpos +: 16];
      case (op)
         OP_LW:   return w;
         OP_LH:   return 32'($signed(h));
         OP_LHU:  return 32'(h);
         OP_LB:   return 32'($signed(b));
         OP_LBU:  return 32'(b);
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] refMerge(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] d, input logic [31:0] w);
      logic [31:0] r = w;
      if (op == OP_SH) r[(a[1] ? 0 : 16) +: 16] = d[15:0];
      else             r[8 * (3 - int'(a[1:0])) +: 8] = d[7:0];
      return r;
   endfunction

   logic        mPend = 1'b0;
   logic [31:0] mPendAddr = '0, mPendData = '0;
   logic        mFv = 1'b0;
   logic [31:0] mFa = '0;

   always begin : model
      logic        eStall, eRead, eWrite, eMis;
      logic [31:0] eLd, eAddr, eWd;
      @(negedge clk);
      if (!reset_n) begin mPend = 0; mFv = 0; mFa = 0; end
      eStall = 0; eRead = 0; eWrite = 0; eLd = 0;
      eAddr  = {req_address[31:2], 2'b00};
      eWd    = req_store_data;
      eMis   = isMis(req_op, req_address);
      if (!reset_n) begin
      end else if (mPend) begin
         eWrite = 1; eAddr = mPendAddr; eWd = mPendData;
      end else if (!eMis) begin
         case (req_op)
            OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: begin
               eRead = 1;
               eLd = refLoad(req_op, req_address, refMem[req_address[7:2]]);
            end
            OP_SW: eWrite = 1;
            OP_SH, OP_SB: begin eRead = 1; eStall = 1; end
            default: ;
         endcase
      end
      check("misaligned", 32'(misaligned), 32'(eMis));
      check("stall", 32'(stall), 32'(eStall));
      check("mem_read", 32'(mem_read), 32'(eRead));
      check("mem_write", 32'(mem_write), 32'(eWrite));
      check("load_data", load_data, eLd);
      if (eRead || eWrite) check("mem_address", mem_address, eAddr);
      if (eWrite) check("mem_write_data", mem_write_data, eWd);
      check("fault_valid", 32'(fault_valid), 32'(mFv));
      check("fault_address", fault_address, mFa);
      @(posedge clk);
      if (!reset_n) begin
         mPend = 0; mFv = 0; mFa = 0;
      end else begin
         if (eWrite) refMem[eAddr[7:2]] = eWd;
         if (eMis && !mFv && !mPend) begin mFv = 1; mFa = req_address; end
         if (mPend) mPend = 0;
         else if (eStall) begin
            mPend = 1; mPendAddr = eAddr;
            mPendData = refMerge(req_op, req_address, req_store_data, refMem[eAddr[7:2]]);
         end
      end
   end

   // ---------------- directed driver ----------------
   // One request per call; aligned SH/SB are held for their two cycles.
   task automatic doOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d,
                       input logic chk, input logic [31:0] ev);
      req_op = op; req_address = a; req_store_data = d;
      $display("op=%0d addr=%h data=%h", op, a, d);
      @(negedge clk);
      if ((op == OP_SH && !a[0]) || op == OP_SB) begin
         check("rmw stall", 32'(stall), 32'd1);
         @(posedge clk); #1;
         @(negedge clk);
         check("rmw write", 32'(mem_write), 32'd1);
         if (chk) check("rmw data", mem_write_data, ev);
      end else if (chk) begin
         check("load literal", load_data, ev);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      int s0;
      for (int i = 0; i < 64; i++) begin dutMem[i] = '0; refMem[i] = '0; end
      repeat (2) @(posedge clk);
      #1;
      check("reset fault_valid", 32'(fault_valid), 32'd0);
      check("reset fault_address", fault_address, 32'd0);
      reset_n = 1'b1;

      // Scenario 1
      doOp(OP_SW,  32'h10, 32'h8899AABB, 0, 0);
      doOp(OP_LW,  32'h10, 0, 1, 32'h8899AABB);
      doOp(OP_LB,  32'h11, 0, 1, 32'hFFFFFF99);
      doOp(OP_LBU, 32'h11, 0, 1, 32'h00000099);
      // Scenario 2
      doOp(OP_SB,  32'h12, 32'hCAFE0055, 1, 32'h889955BB);
      doOp(OP_LW,  32'h10, 0, 1, 32'h889955BB);
      doOp(OP_LH,  32'h10, 0, 1, 32'hFFFF8899);
      doOp(OP_LB,  32'h13, 0, 1, 32'hFFFFFFBB);
      doOp(OP_LBU, 32'h13, 0, 1, 32'h000000BB);
      doOp(4'd6,   32'h10, 0, 1, 32'h0);
      // Scenario 3
      doOp(OP_SH,  32'h16, 32'hABCD1234, 1, 32'h00001234);
      doOp(OP_LH,  32'h16, 0, 1, 32'h00001234);
      doOp(OP_LHU, 32'h14, 0, 1, 32'h00000000);
      check("word 0x14", dutMem[5], 32'h00001234);
      // Scenario 4
      doOp(OP_LW,  32'h21, 0, 0, 0);
      check("fault addr first", fault_address, 32'h21);
      doOp(OP_SH,  32'h33, 32'h7777, 0, 0);
      check("fault_valid sticky", 32'(fault_valid), 32'd1);
      check("fault addr kept", fault_address, 32'h21);
      // Scenario 5: reset lands while the RMW write is pending
      req_op = OP_SB; req_address = 32'h40; req_store_data = 32'hFF;
      $display("op=%0d addr=%h data=%h (reset in write cycle)", req_op, req_address, req_store_data);
      @(posedge clk); #1;
      reset_n = 1'b0;
      @(negedge clk);
      check("reset kills write", 32'(mem_write), 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1; req_op = OP_NONE;
      @(negedge clk);
      check("word 0x40 untouched", dutMem[16], 32'h0);
      check("fault cleared", 32'(fault_valid), 32'd0);
      @(posedge clk); #1;
      doOp(OP_LW,  32'h40, 0, 1, 32'h0);
      // Scenario 6
      s0 = stallCount;
      doOp(OP_SB,  32'h50, 32'h01, 1, 32'h01000000);
      doOp(OP_SB,  32'h51, 32'h02, 1, 32'h01020000);
      check("b2b stall cycles", 32'(stallCount - s0), 32'd2);
      check("word 0x50", dutMem[20], 32'h01020000);
      doOp(OP_NONE, 32'h0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

endmodule
